// File: rtl/sr_pulse_gen.sv
// SR latch front end: button synchronisers, optional debounce, and mutually exclusive s/r/enable pulse FSM.
// Debounce filter is built only when SR_DEBOUNCE_EN is defined.
module sr_pulse_gen #(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic enable,
  output logic busy,
  output logic conflict
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);
  localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SET_P = 2'd1;
  localparam logic [1:0] RST_P = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  if (DB_CYCLES < 1 || PULSE_LEN < 1) begin : g_bad_params
  end

  // channel 0 = set, channel 1 = clear
  logic [1:0][1:0] r_sync;
  logic [1:0]      w_sync;
  logic [1:0]      w_filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else begin
      r_sync[0] <= {r_sync[0][0], set_btn};
      r_sync[1] <= {r_sync[1][0], rst_btn};
    end
  end

  assign w_sync = {r_sync[1][1], r_sync[0][1]};

`ifdef SR_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [1:0][DW-1:0] r_db_cnt;
  logic [1:0]         r_filt;

  // The edge that completes DB_CYCLES mismatching cycles also updates the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_filt   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_filt[i]) r_db_cnt[i] <= '0;
        else if (r_db_cnt[i] == DB_LAST) begin
          r_filt[i]   <= w_sync[i];
          r_db_cnt[i] <= '0;
        end else r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = w_sync;
`endif

  logic [1:0] r_filt_d;
  logic [1:0] r_req;
  logic [1:0] r_pend;
  logic [1:0] r_state;
  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt_d <= '0;
      r_req    <= '0;
    end else begin
      r_filt_d <= w_filt;
      r_req    <= w_filt & ~r_filt_d;
    end
  end

  logic [1:0] w_eff;
  logic [1:0] w_ns;
  logic [1:0] w_pend_nxt;
  logic       w_conf;
  logic       w_load;

  assign w_eff = r_pend | r_req;

  // GAP decides like IDLE so a queued request starts right after the gap cycle.
  always_comb begin
    w_ns       = r_state;
    w_pend_nxt = w_eff;
    w_conf     = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      IDLE, GAP: begin
        w_ns = IDLE;
        if (w_eff == 2'b11) begin
          w_conf     = 1'b1;
          w_pend_nxt = 2'b00;
        end else if (w_eff[0]) begin
          w_ns          = SET_P;
          w_pend_nxt[0] = 1'b0;
          w_load        = 1'b1;
        end else if (w_eff[1]) begin
          w_ns          = RST_P;
          w_pend_nxt[1] = 1'b0;
          w_load        = 1'b1;
        end
      end
      SET_P, RST_P: if (r_cnt == PULSE_ONE) w_ns = GAP;
      default: w_ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_cnt    <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      r_state  <= w_ns;
      r_pend   <= w_pend_nxt;
      if (w_load) r_cnt <= PULSE_LOAD;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      s        <= (w_ns == SET_P);
      r        <= (w_ns == RST_P);
      enable   <= (w_ns == SET_P) || (w_ns == RST_P);
      busy     <= (w_ns != IDLE);
      conflict <= w_conf;
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Bench for sr_pulse_gen: timeline model of pulses/conflicts checked every cycle, plus literal latency pins.
module tb_sr_pulse_gen;
  localparam int DB = 4;
  localparam int PL = 2;
`ifdef SR_DEBOUNCE_EN
  localparam int LAT  = 3 + DB;
  localparam bit DBON = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit DBON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic s, r, enable, busy, conflict;

  sr_pulse_gen #(.DB_CYCLES(DB), .PULSE_LEN(PL)) dut (
    .clk(clk), .reset(reset), .set_btn(set_btn), .rst_btn(rst_btn),
    .s(s), .r(r), .enable(enable), .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // Model: button history -> filtered level -> request times; a pulse occupies
  // [start, start+PL) high, then one quiet cycle; next start no earlier than start+PL+1.
  bit [1:0] m_s1 = '0, m_s2 = '0, m_filt = '0, m_fd = '0, m_req = '0, m_pend = '0;
  int m_run[2] = '{0, 0};
  int free_at = 0, start_t = -1000, conf_t = -1000;
  bit kind_set = 1'b0;

  always @(posedge clk) begin
    bit [1:0] btn, filt_cur, req_old, eff;
    cyc = cyc + 1;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_fd = '0; m_req = '0; m_pend = '0;
      m_run[0] = 0; m_run[1] = 0;
      free_at = 0; start_t = -1000; conf_t = -1000;
    end else begin
      btn      = {rst_btn, set_btn};
      filt_cur = DBON ? m_filt : m_s2;
      req_old  = m_req;
      m_req    = filt_cur & ~m_fd;
      m_fd     = filt_cur;
      if (DBON) begin
        for (int i = 0; i < 2; i++) begin
          if (m_s2[i] != m_filt[i]) begin
            m_run[i]++;
            if (m_run[i] >= DB) begin
              m_filt[i] = m_s2[i];
              m_run[i]  = 0;
            end
          end else m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
      eff = m_pend | req_old;
      if (cyc >= free_at) begin
        if (eff == 2'b11) conf_t = cyc;
        else if (eff != 2'b00) begin
          kind_set = eff[0];
          start_t  = cyc;
          free_at  = cyc + PL + 1;
        end
        m_pend = '0;
      end else m_pend = eff;
    end
  end

  int s_rise = 0, r_rise = 0, conf_cnt = 0, busy_cnt = 0, last_rise = -1;
  logic s_q = 1'b0, r_q = 1'b0;

  always @(negedge clk) begin
    int d;
    bit e_s, e_r, e_b;
    d   = cyc - start_t;
    e_s = kind_set && d >= 0 && d < PL;
    e_r = !kind_set && d >= 0 && d < PL;
    e_b = d >= 0 && d <= PL;
    chk("model_s", s, e_s);
    chk("model_r", r, e_r);
    chk("model_enable", enable, e_s | e_r);
    chk("model_busy", busy, e_b);
    chk("model_conflict", conflict, conf_t == cyc);
    chk("inv_s_and_r", s & r, 1'b0);
    chk("inv_enable", enable, s | r);
    if ((s && !s_q) || (r && !r_q)) begin
      if (last_rise >= 0) chk("pulse_spacing", (cyc - last_rise) >= PL + 1, 1'b1);
      last_rise = cyc;
    end
    if (s && !s_q) s_rise++;
    if (r && !r_q) r_rise++;
    if (conflict) conf_cnt++;
    if (busy) busy_cnt++;
    s_q = s;
    r_q = r;
  end

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e0, bs, br, bc, bb;
    repeat (3) @(negedge clk);
    chk("reset_s", s, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_conflict", conflict, 1'b0);
    reset = 1'b0;
    idle(10);

    // single set press held
    e0 = cyc + 1;
    set_btn = 1'b1;
    wait_to(e0 + LAT - 1);
    chk("t1_s_before", s, 1'b0);
    wait_to(e0 + LAT);
    chk("t1_s_first", s, 1'b1);
    chk("t1_en_first", enable, 1'b1);
    chk("t1_r_first", r, 1'b0);
    wait_to(e0 + LAT + 1);
    chk("t1_s_second", s, 1'b1);
    wait_to(e0 + LAT + 2);
    chk("t1_s_gap", s, 1'b0);
    chk("t1_busy_gap", busy, 1'b1);
    wait_to(e0 + LAT + 3);
    chk("t1_busy_idle", busy, 1'b0);
    set_btn = 1'b0;
    idle(20);

    // bouncing set button
    bs = s_rise; bb = busy_cnt;
    for (int i = 0; i < 12; i++) begin
      set_btn = ((i >> 1) & 1) == 0;
      @(negedge clk);
    end
    set_btn = 1'b0;
    idle(25);
    if (DBON) begin
      chk_i("t2_no_pulse", s_rise - bs, 0);
      chk_i("t2_no_busy", busy_cnt - bb, 0);
    end else begin
      chk_i("t2_bounce_pulses", s_rise - bs, 3);
    end

    // simultaneous set and clear
    bs = s_rise; br = r_rise; bc = conf_cnt;
    e0 = cyc + 1;
    set_btn = 1'b1;
    rst_btn = 1'b1;
    wait_to(e0 + LAT);
    chk("t3_conflict", conflict, 1'b1);
    wait_to(e0 + LAT + 1);
    chk("t3_conflict_drop", conflict, 1'b0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    idle(20);
    chk_i("t3_conflict_cnt", conf_cnt - bc, 1);
    chk_i("t3_no_s", s_rise - bs, 0);
    chk_i("t3_no_r", r_rise - br, 0);

    // clear arrives during set pulse
    e0 = cyc + 1;
    set_btn = 1'b1;
    @(negedge clk);
    rst_btn = 1'b1;
    wait_to(e0 + LAT);
    chk("t4_s_on", s, 1'b1);
    wait_to(e0 + LAT + 2);
    chk("t4_gap_en", enable, 1'b0);
    wait_to(e0 + LAT + 3);
    chk("t4_r_on", r, 1'b1);
    chk("t4_s_off", s, 1'b0);
    wait_to(e0 + LAT + 4);
    chk("t4_r_hold", r, 1'b1);
    wait_to(e0 + LAT + 5);
    chk("t4_r_done", r, 1'b0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    idle(20);

    // reset in the middle of a set pulse
    e0 = cyc + 1;
    set_btn = 1'b1;
    wait_to(e0 + LAT);
    chk("t5_s_pre", s, 1'b1);
    set_btn = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_s_async", s, 1'b0);
    chk("t5_en_async", enable, 1'b0);
    chk("t5_busy_async", busy, 1'b0);
    idle(3);
    reset = 1'b0;
    bs = s_rise; br = r_rise; bb = busy_cnt;
    idle(25);
    chk_i("t5_no_s", s_rise - bs, 0);
    chk_i("t5_no_r", r_rise - br, 0);
    chk_i("t5_no_busy", busy_cnt - bb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
